// File: rtl/sram_model_pkg.sv
// sram_model_pkg: shared controller state type and lane-count helper for sram_1rw1r_wmask
package sram_model_pkg;
  typedef enum logic {INIT, READY} state_t;
  // Lane count; a non-divisible word width yields 0 so the top's elaboration check trips.
  function automatic int num_wmasks(input int data_width, input int wmask_width);
    return (wmask_width > 0 && data_width % wmask_width == 0) ? data_width / wmask_width : 0;
  endfunction
endpackage

// File: rtl/sram_init_ctrl.sv
// sram_init_ctrl: post-reset zero-scrub sequencer
//   clk0, rstb0        clock, async active-low reset
//   init_done          high once the memory accepts commands
//   scrub_we/scrub_addr  one zero-write per cycle, ascending, while scrubbing
module sram_init_ctrl
  import sram_model_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  output logic                  init_done,
  output logic                  scrub_we,
  output logic [ADDR_WIDTH-1:0] scrub_addr
);
  state_t state, state_n;
  assign scrub_we = state == INIT;
  // Scrub ends on the edge that writes the last address; the counter saturates there.
  always_comb begin
    state_n = (state == INIT && &scrub_addr) ? READY : state;
  end
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state      <= (INIT_ZERO != 0) ? INIT : READY;
      scrub_addr <= '0;
      init_done  <= 1'b0;
    end else begin
      state     <= state_n;
      init_done <= state_n == READY;
      if (scrub_we && !(&scrub_addr)) scrub_addr <= scrub_addr + 1'b1;
    end
  end
endmodule

// File: rtl/sram_1rw1r_wmask.sv
// sram_1rw1r_wmask: one read/write port (lane-masked writes) plus one read-only port
//   clk0, rstb0              clock, async active-low reset
//   csb0, web0, wmask0       port 0 select (low), write enable (low), lane enables
//   addr0, din0, dout0       port 0 address, write data, read data
//   csb1, addr1, dout1       port 1 select (low), address, read data
//   init_done                high once the post-reset scrub has finished
module sram_1rw1r_wmask
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int WMASK_WIDTH  = 8,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1,
  localparam int NUM_WMASKS  = num_wmasks(DATA_WIDTH, WMASK_WIDTH)
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  init_done
);
  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
  if (NUM_WMASKS == 0) begin : g_bad_mask
    $fatal(1, "DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  scrub_we;
  logic [ADDR_WIDTH-1:0] scrub_addr;
  logic                  rd0, wr0, rd1;
  sram_init_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_ZERO(INIT_ZERO)) u_init (
    .clk0      (clk0),
    .rstb0     (rstb0),
    .init_done (init_done),
    .scrub_we  (scrub_we),
    .scrub_addr(scrub_addr)
  );
  // Commands are dropped, not queued, until the scrub completes.
  assign rd0 = init_done && !csb0 && web0;
  assign wr0 = init_done && !csb0 && !web0;
  assign rd1 = init_done && !csb1;
  // Memory has no reset; only the scrub clears it.
  always_ff @(posedge clk0) begin
    if (scrub_we) mem[scrub_addr] <= '0;
    else if (wr0)
      for (int i = 0; i < NUM_WMASKS; i++)
        if (wmask0[i]) mem[addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= din0[i*WMASK_WIDTH +: WMASK_WIDTH];
  end
  // The array is read on the sampling edge, so a same-cycle write is never seen (read-before-write).
  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
        dout0 <= '0;
        dout1 <= '0;
      end else begin
        if (rd0) dout0 <= mem[addr0];
        if (rd1) dout1 <= mem[addr1];
      end
    end
  end else begin : g_lat2
    logic                  v0, v1;
    logic [DATA_WIDTH-1:0] p0, p1;
    always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
        v0    <= 1'b0;
        v1    <= 1'b0;
        p0    <= '0;
        p1    <= '0;
        dout0 <= '0;
        dout1 <= '0;
      end else begin
        v0 <= rd0;
        v1 <= rd1;
        if (rd0) p0 <= mem[addr0];
        if (rd1) p1 <= mem[addr1];
        if (v0) dout0 <= p0;
        if (v1) dout1 <= p1;
      end
    end
  end
endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// tb_sram_1rw1r_wmask: directed vectors against latency-1 and latency-2 instances sharing one stimulus
module tb_sram_1rw1r_wmask;
  logic        clk0 = 1'b0;
  logic        rstb0 = 1'b0;
  logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0;
  logic [31:0] a_d0, a_d1, b_d0, b_d1;
  logic        a_done, b_done;
  int          n_cmp = 0, n_fail = 0;

  always #5 clk0 = ~clk0;

  sram_1rw1r_wmask #(.READ_LATENCY(1)) dut_a (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(a_d0), .csb1(csb1), .addr1(addr1), .dout1(a_d1), .init_done(a_done)
  );
  sram_1rw1r_wmask #(.READ_LATENCY(2)) dut_b (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(b_d0), .csb1(csb1), .addr1(addr1), .dout1(b_d1), .init_done(b_done)
  );

  typedef struct {
    logic        csb0, web0;
    logic [3:0]  wmask;
    logic [7:0]  a0;
    logic [31:0] din;
    logic        csb1;
    logic [7:0]  a1;
    logic [31:0] e0, e1;
  } vec_t;
  vec_t v[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [3:0] m, input logic [7:0] a0,
                       input logic [31:0] d, input logic c1, input logic [7:0] a1);
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_dout"}, a_d0 | a_d1 | b_d0 | b_d1, 32'h0);
  endtask

  // n scrub cycles after a release, outputs must stay zero; done must rise on cycle 256 exactly
  task automatic run_init(input string name, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk_quiet(name);
      if (i == 255) chk({name, "_done_early"}, {30'b0, a_done, b_done}, 32'h0);
      if (i == 256) begin
        chk({name, "_done_at_256"}, {30'b0, a_done, b_done}, 32'h3);
        drive(1, 1, 4'h0, 8'h0, 32'h0, 1, 8'h0);
      end
    end
  endtask

  initial begin
    logic [31:0] ea [5];
    logic [31:0] eb [5];
    v[0]  = '{1, 1, 4'hF, 8'd0,   32'h0,        1, 8'd255, 32'h0,        32'h0};
    v[0].csb0 = 0; v[0].csb1 = 0;
    v[1]  = '{0, 0, 4'hF, 8'd5,   32'hDEADBEEF, 0, 8'd77,  32'h0,        32'h0};
    v[2]  = '{0, 0, 4'h5, 8'd5,   32'h11223344, 0, 8'd5,   32'h0,        32'hDEADBEEF};
    v[3]  = '{0, 1, 4'h0, 8'd5,   32'h0,        0, 8'd5,   32'hDE22BE44, 32'hDE22BE44};
    v[4]  = '{0, 0, 4'hF, 8'd9,   32'hAAAAAAAA, 0, 8'd9,   32'hDE22BE44, 32'h0};
    v[5]  = '{1, 1, 4'h0, 8'd0,   32'h0,        0, 8'd9,   32'hDE22BE44, 32'hAAAAAAAA};
    v[6]  = '{0, 0, 4'h0, 8'd9,   32'h55555555, 0, 8'd9,   32'hDE22BE44, 32'hAAAAAAAA};
    v[7]  = '{0, 1, 4'h0, 8'd9,   32'h0,        1, 8'd0,   32'hAAAAAAAA, 32'hAAAAAAAA};
    v[8]  = '{0, 0, 4'hF, 8'd200, 32'hCAFEF00D, 1, 8'd0,   32'hAAAAAAAA, 32'hAAAAAAAA};
    v[9]  = '{0, 0, 4'h8, 8'd200, 32'h12345678, 0, 8'd200, 32'hAAAAAAAA, 32'hCAFEF00D};
    v[10] = '{0, 1, 4'h0, 8'd200, 32'h0,        0, 8'd5,   32'h12FEF00D, 32'hDE22BE44};
    v[11] = '{1, 1, 4'h0, 8'd0,   32'h0,        1, 8'd0,   32'h12FEF00D, 32'hDE22BE44};
    v[12] = '{1, 0, 4'hF, 8'd200, 32'h0,        1, 8'd0,   32'h12FEF00D, 32'hDE22BE44};
    v[13] = '{0, 1, 4'h0, 8'd200, 32'h0,        0, 8'd200, 32'h12FEF00D, 32'h12FEF00D};

    repeat (3) @(posedge clk0);
    #1;
    chk("reset_dout", a_d0 | a_d1 | b_d0 | b_d1, 32'h0);
    chk("reset_done", {30'b0, a_done, b_done}, 32'h0);

    // First scrub, with reads pending that must be dropped
    drive(0, 1, 4'h0, 8'd200, 32'h0, 0, 8'd200);
    rstb0 = 1'b1;
    run_init("init1", 256);

    // Vector table: latency-2 instance lags the latency-1 expectation by one edge
    for (int i = 0; i < 14; i++) begin
      drive(v[i].csb0, v[i].web0, v[i].wmask, v[i].a0, v[i].din, v[i].csb1, v[i].a1);
      tick();
      chk($sformatf("vec%0d_l1_dout0", i), a_d0, v[i].e0);
      chk($sformatf("vec%0d_l1_dout1", i), a_d1, v[i].e1);
      chk($sformatf("vec%0d_l2_dout0", i), b_d0, i == 0 ? 32'h0 : v[i-1].e0);
      chk($sformatf("vec%0d_l2_dout1", i), b_d1, i == 0 ? 32'h0 : v[i-1].e1);
    end
    drive(1, 1, 4'h0, 8'h0, 32'h0, 1, 8'h0);
    tick();
    chk("vec_tail_l2_dout0", b_d0, 32'h12FEF00D);
    chk("vec_tail_l2_dout1", b_d1, 32'h12FEF00D);

    // Reset with a latency-2 read in flight: outputs clear at once and the read never lands
    drive(0, 1, 4'h0, 8'd5, 32'h0, 0, 8'd9);
    tick();
    chk("preabort_l1_dout0", a_d0, 32'hDE22BE44);
    chk("preabort_l1_dout1", a_d1, 32'hAAAAAAAA);
    rstb0 = 1'b0;
    #1;
    chk("abort_dout", a_d0 | a_d1 | b_d0 | b_d1, 32'h0);
    chk("abort_done", {30'b0, a_done, b_done}, 32'h0);
    tick();
    tick();
    chk("abort_no_late_read", b_d0 | b_d1, 32'h0);

    // Second scrub interrupted at cycle 100; addr 200 still holds data until scrubbed
    drive(0, 1, 4'h0, 8'd200, 32'h0, 0, 8'd200);
    rstb0 = 1'b1;
    run_init("init2", 100);
    rstb0 = 1'b0;
    #1;
    chk("midinit_reset_dout", a_d0 | a_d1 | b_d0 | b_d1, 32'h0);
    chk("midinit_reset_done", {30'b0, a_done, b_done}, 32'h0);
    tick();
    rstb0 = 1'b1;
    run_init("init3", 256);

    // Back-to-back reads of 1,2,3 on both ports
    drive(0, 0, 4'hF, 8'd1, 32'h11111111, 1, 8'd0); tick();
    drive(0, 0, 4'hF, 8'd2, 32'h22222222, 1, 8'd0); tick();
    drive(0, 0, 4'hF, 8'd3, 32'h33333333, 1, 8'd0); tick();
    ea = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333, 32'h33333333};
    eb = '{32'h0,        32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(0, 1, 4'h0, 8'(i + 1), 32'h0, 0, 8'(i + 1));
      else drive(1, 1, 4'h0, 8'h0, 32'h0, 1, 8'h0);
      tick();
      chk($sformatf("b2b%0d_l1_dout0", i), a_d0, ea[i]);
      chk($sformatf("b2b%0d_l1_dout1", i), a_d1, ea[i]);
      chk($sformatf("b2b%0d_l2_dout0", i), b_d0, eb[i]);
      chk($sformatf("b2b%0d_l2_dout1", i), b_d1, eb[i]);
    end

    // Previously written addresses must have been scrubbed to zero
    drive(0, 1, 4'h0, 8'd200, 32'h0, 0, 8'd5);
    tick();
    chk("scrubbed_l1", a_d0 | a_d1, 32'h0);
    chk("scrubbed_l2_pending", b_d0 & b_d1, 32'h33333333);
    drive(1, 1, 4'h0, 8'h0, 32'h0, 1, 8'h0);
    tick();
    chk("scrubbed_l2", b_d0 | b_d1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
